ring_osc_model: RTL and testbench
=================================

Name: ring_osc_model

Overview:
- Cycle-based, parametrised model of an N-stage inverter ring oscillator for digital-only and mixed-signal co-simulation.
- Each stage is an inverter with an inertial delay counted in clock cycles.
- Adds an enable, a runtime slow mode that doubles the stage delay, stage tap outputs, and an on-chip period/edge monitor.
- Sits in the example/test tree as the clocked successor of the free-running behavioural inverter ring.

Parameters:
- STAGES, 5, number of inverter stages; must be odd and ≥3.
- DELAY, 10, per-stage delay in clock cycles; must be ≥1.
- CNT_W, 16, width of period_o and edge_cnt_o.

Ports:
- clk  input  1  model time base; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  closes the ring when 1; forces stage-0 input to 0 when 0.
- slow  input  1  when 1, per-stage threshold is 2*DELAY instead of DELAY.
- taps_o  output  STAGES  stage outputs; bit i is the output of stage i.
- osc_o  output  1  equals taps_o[STAGES-1].
- period_o  output  CNT_W  last measured osc_o rising-to-rising period, in clocks.
- period_valid_o  output  1  one-cycle pulse when period_o updates.
- edge_cnt_o  output  CNT_W  count of osc_o rising edges; wraps.

Behaviour:
- Reset (async, rst_n=0):
  - taps_o[i] = 1 for even i, 0 for odd i. This is the quiescent pattern for en=0.
  - All stage counters = 0; period counter = 0; period_o = 0; period_valid_o = 0; edge_cnt_o = 0; armed = 0.
- Stage inputs:
  - Stage 0 input = en ? taps_o[STAGES-1] : 0.
  - Stage i>0 input = taps_o[i-1].
- Mismatch: a stage has a mismatch when its output equals its input.
- Stage timing, threshold T = slow ? 2*DELAY : DELAY:
  - No mismatch: cnt <= 0.
  - Mismatch and cnt ≥ T-1: output toggles and cnt <= 0.
  - Mismatch otherwise: cnt++.
  - Result: an input change first sampled at edge k toggles the output at edge k+T-1. The next stage sees it from edge k+T.
- Inertial filtering: a mismatch lasting fewer than T consecutive edges is swallowed; the counter clears and the output does not change.
- Change of slow mid-count:
  - The new T applies from that edge.
  - If cnt already ≥ new T-1, the stage toggles on that edge.
- Oscillation:
  - With en=1 and constant slow, period = 2*STAGES*T clocks, 50% duty.
  - The first osc_o fall occurs STAGES*T-1 edges after en is first sampled high from reset state.
- Disable: when en drops, in-flight transitions complete. The ring then settles to the reset pattern within STAGES*T edges and stays static.
- Period monitor:
  - pcnt increments every edge and saturates at all-ones.
  - Rising edge of osc_o (registered compare of old/new tap value):
    - If armed: period_o <= pcnt+1 (saturating) and period_valid_o = 1 for one cycle.
    - Always: armed <= 1, pcnt <= 0, edge_cnt_o++ (wraps at 2^CNT_W).
  - en=0 clears armed and pcnt; period_o holds its last value.
- Reset mid-operation: all state returns to reset values immediately (async). No pulse is emitted on reset release.
- slow and en are synchronous inputs sampled on clk.

Test Plan:
- Reset with en=0, STAGES=5, DELAY=10 -> taps_o=5'b10101, osc_o=1, period_valid_o=0, edge_cnt_o=0. Hold 500 cycles -> no change.
- en=1 first sampled at edge e -> taps_o[0] falls at e+9, osc_o falls at e+49, rises at e+99. First period_valid_o pulse at e+199 with period_o=100; edge_cnt_o=2 after that edge.
- slow=1 during steady oscillation -> after one transient period, period_o=200 on every subsequent pulse.
- Force a 5-cycle glitch by dropping en and restoring it while osc_o=1 and stage 0 is idle -> taps_o[0] never toggles, period stays 100.
- en=0 mid-oscillation -> ring settles to 5'b10101 within 50 edges; period_valid_o stays 0 while en=0. Re-enable -> first valid period is again 100.
- rst_n pulsed low mid-count -> outputs return to reset values in the same cycle. CNT_W=4 run -> edge_cnt_o wraps 15->0, period_o saturates at 15.

Source files
------------

// File: rtl/ring_osc_model.sv
// Cycle-based N-stage inverter ring oscillator with inertial stage delays,
// enable, slow mode, stage taps and an osc_o period/edge monitor.
module ring_osc_model #(
  parameter int STAGES = 5,
  parameter int DELAY  = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              slow,
  output logic [STAGES-1:0] taps_o,
  output logic              osc_o,
  output logic [CNT_W-1:0]  period_o,
  output logic              period_valid_o,
  output logic [CNT_W-1:0]  edge_cnt_o
);

  localparam int CTR_W = $clog2(2*DELAY+1);
  localparam logic [CTR_W-1:0] THR_FAST = CTR_W'(DELAY-1);
  localparam logic [CTR_W-1:0] THR_SLOW = CTR_W'(2*DELAY-1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [STAGES-1:0] quietPattern();
    logic [STAGES-1:0] p;
    for (int i = 0; i < STAGES; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [STAGES-1:0] RESET_PAT = quietPattern();

  logic [STAGES-1:0] taps_q, taps_d, stageIn;
  logic [CTR_W-1:0]  cnt_q [STAGES];
  logic [CTR_W-1:0]  cnt_d [STAGES];
  logic [CTR_W-1:0]  thrM1;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d, period_q, period_d, edge_q, edge_d;
  logic              armed_q, armed_d, valid_q, valid_d, oscRise;

  assign stageIn = {taps_q[STAGES-2:0], en & taps_q[STAGES-1]};

  // A stage whose output equals its input is mismatched and must hold that
  // mismatch for T consecutive edges before it toggles.
  always_comb begin
    thrM1  = slow ? THR_SLOW : THR_FAST;
    taps_d = taps_q;
    for (int i = 0; i < STAGES; i++) begin
      cnt_d[i] = '0;
      if (taps_q[i] == stageIn[i]) begin
        if (cnt_q[i] >= thrM1) taps_d[i] = ~taps_q[i];
        else                   cnt_d[i]  = cnt_q[i] + CTR_W'(1);
      end
    end
  end

  // Disable dominates: it drops the arm so a rise seen while settling is never
  // used as the start of a measured period.
  always_comb begin
    oscRise  = ~taps_q[STAGES-1] & taps_d[STAGES-1];
    edge_d   = oscRise ? edge_q + CNT_W'(1) : edge_q;
    period_d = period_q;
    valid_d  = 1'b0;
    armed_d  = armed_q;
    pcnt_d   = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_W'(1);
    if (!en) begin
      armed_d = 1'b0;
      pcnt_d  = '0;
    end else if (oscRise) begin
      if (armed_q) begin
        period_d = (pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + CNT_W'(1);
        valid_d  = 1'b1;
      end
      armed_d = 1'b1;
      pcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q   <= RESET_PAT;
      for (int i = 0; i < STAGES; i++) cnt_q[i] <= '0;
      pcnt_q   <= '0;
      period_q <= '0;
      edge_q   <= '0;
      armed_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      taps_q   <= taps_d;
      for (int i = 0; i < STAGES; i++) cnt_q[i] <= cnt_d[i];
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      edge_q   <= edge_d;
      armed_q  <= armed_d;
      valid_q  <= valid_d;
    end
  end

  assign taps_o         = taps_q;
  assign osc_o          = taps_q[STAGES-1];
  assign period_o       = period_q;
  assign period_valid_o = valid_q;
  assign edge_cnt_o     = edge_q;

endmodule

// File: tb/tb_ring_osc_model.sv
// Bench for ring_osc_model: directed test-plan steps plus random en/slow
// segments, all checked every cycle against a timestamp-based reference.
module tb_ring_osc_model;

  localparam int S = 5;
  localparam int D = 10;

  logic        clk = 1'b0;
  logic        rst_n, en, slow;
  logic [4:0]  tapsA, tapsB;
  logic        oscA, oscB, validA, validB;
  logic [15:0] periodA, edgeA;
  logic [3:0]  periodB, edgeB;

  int checks = 0;
  int errors = 0;

  bit mTaps [S];
  int mStart[S];
  int now, rises, lastRise, periodRaw;
  bit armed, validExp;

  ring_osc_model #(.STAGES(S), .DELAY(D), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .en(en), .slow(slow),
    .taps_o(tapsA), .osc_o(oscA), .period_o(periodA),
    .period_valid_o(validA), .edge_cnt_o(edgeA)
  );

  ring_osc_model #(.STAGES(S), .DELAY(D), .CNT_W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .en(en), .slow(slow),
    .taps_o(tapsB), .osc_o(oscB), .period_o(periodB),
    .period_valid_o(validB), .edge_cnt_o(edgeB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int satW(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < S; i++) begin
      mTaps[i]  = (i % 2 == 0);
      mStart[i] = -1;
    end
    now = 0; rises = 0; lastRise = 0; periodRaw = 0;
    armed = 0; validExp = 0;
  endtask

  // Each stage remembers the edge at which its current mismatch began; it
  // toggles once the mismatch has been seen for T edges under the present T.
  task automatic modelEdge();
    int T;
    bit inp[S];
    bit nxt[S];
    bit rise;
    T = slow ? 2*D : D;
    inp[0] = en ? mTaps[S-1] : 1'b0;
    for (int i = 1; i < S; i++) inp[i] = mTaps[i-1];
    for (int i = 0; i < S; i++) begin
      nxt[i] = mTaps[i];
      if (mTaps[i] != inp[i]) mStart[i] = -1;
      else begin
        if (mStart[i] < 0) mStart[i] = now;
        if (now - mStart[i] >= T - 1) begin
          nxt[i]    = !mTaps[i];
          mStart[i] = -1;
        end
      end
    end
    rise = !mTaps[S-1] && nxt[S-1];
    for (int i = 0; i < S; i++) mTaps[i] = nxt[i];
    if (rise) rises++;
    validExp = 0;
    if (!en) armed = 0;
    else if (rise) begin
      if (armed) begin
        validExp  = 1;
        periodRaw = now - lastRise;
      end
      armed    = 1;
      lastRise = now;
    end
    now++;
  endtask

  task automatic checkOutput();
    logic [4:0] et;
    for (int i = 0; i < S; i++) et[i] = mTaps[i];
    check("tapsA", tapsA, et);
    check("oscA", oscA, et[4]);
    check("validA", validA, validExp);
    check("periodA", periodA, satW(periodRaw, 16));
    check("edgeA", edgeA, rises % 65536);
    check("tapsB", tapsB, et);
    check("validB", validB, validExp);
    check("periodB", periodB, satW(periodRaw, 4));
    check("edgeB", edgeB, rises % 16);
  endtask

  task automatic applyStimulus(input bit inEn, input bit inSlow, input int n);
    en   = inEn;
    slow = inSlow;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
    end
  endtask

  initial begin
    int  cyc;
    bit  sawValid;
    bit  rEn, rSlow;
    int  rLen;

    rst_n = 1'b0; en = 1'b0; slow = 1'b0;
    modelReset();
    #12;
    rst_n = 1'b1;
    checkOutput();
    check("reset taps", tapsA, 5'b10101);
    check("reset osc", oscA, 1);
    check("reset valid", validA, 0);
    check("reset edge", edgeA, 0);

    applyStimulus(0, 0, 500);
    check("quiet hold taps", tapsA, 5'b10101);

    applyStimulus(1, 0, 9);
    check("tap0 before e+9", tapsA[0], 1);
    applyStimulus(1, 0, 1);
    check("tap0 falls e+9", tapsA[0], 0);
    applyStimulus(1, 0, 39);
    check("osc before e+49", oscA, 1);
    applyStimulus(1, 0, 1);
    check("osc falls e+49", oscA, 0);
    applyStimulus(1, 0, 49);
    check("osc before e+99", oscA, 0);
    applyStimulus(1, 0, 1);
    check("osc rises e+99", oscA, 1);
    check("edge after e+99", edgeA, 1);
    applyStimulus(1, 0, 99);
    check("no pulse before e+199", validA, 0);
    applyStimulus(1, 0, 1);
    check("first pulse e+199", validA, 1);
    check("first period", periodA, 100);
    check("edge after e+199", edgeA, 2);
    check("periodB saturates", periodB, 15);

    applyStimulus(1, 1, 1000);
    check("slow period", periodA, 200);
    applyStimulus(1, 0, 600);
    check("fast period again", periodA, 100);

    cyc = 0;
    while (cyc < 300 && validA !== 1'b1) begin
      applyStimulus(1, 0, 1);
      cyc++;
    end
    check("wait rise before glitch", validA, 1);
    applyStimulus(1, 0, 15);
    check("tap0 idle before glitch", tapsA[0], 0);
    applyStimulus(0, 0, 5);
    check("tap0 during glitch", tapsA[0], 0);
    applyStimulus(1, 0, 5);
    check("tap0 after glitch", tapsA[0], 0);
    applyStimulus(1, 0, 300);
    check("period after glitch", periodA, 100);

    sawValid = 0;
    for (int k = 0; k < 50; k++) begin
      applyStimulus(0, 0, 1);
      if (validA === 1'b1) sawValid = 1;
    end
    check("no pulse while disabled", sawValid, 0);
    check("settled taps", tapsA, 5'b10101);
    applyStimulus(0, 0, 100);
    check("still settled", tapsA, 5'b10101);

    cyc = 0;
    while (cyc < 400 && validA !== 1'b1) begin
      applyStimulus(1, 0, 1);
      cyc++;
    end
    check("reenable pulse seen", validA, 1);
    check("reenable latency", cyc, 200);
    check("reenable period", periodA, 100);

    cyc = 0;
    while (cyc < 3000 && edgeB !== 4'd15) begin
      applyStimulus(1, 0, 1);
      cyc++;
    end
    check("edgeB reaches 15", edgeB, 15);
    cyc = 0;
    while (cyc < 300 && edgeB === 4'd15) begin
      applyStimulus(1, 0, 1);
      cyc++;
    end
    check("edgeB wraps", edgeB, 0);

    for (int seg = 0; seg < 40; seg++) begin
      rEn   = ($urandom_range(0, 4) != 0);
      rSlow = ($urandom_range(0, 3) == 0);
      rLen  = $urandom_range(1, 120);
      applyStimulus(rEn, rSlow, rLen);
    end

    applyStimulus(1, 0, 137);
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    check("async taps", tapsA, 5'b10101);
    check("async valid", validA, 0);
    check("async period", periodA, 0);
    check("async edge", edgeA, 0);
    check("async edgeB", edgeB, 0);
    #2;
    rst_n = 1'b1;
    applyStimulus(1, 0, 250);
    check("period after reset", periodA, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
